// File: rtl/vote_pkg.sv
// Shared definitions for the ballot collector.
// Candidate codes are one-hot so a voter output can be formed by simple bit
// counting; ABSTAIN (000) marks a slot that has not voted.
package vote_pkg;

    localparam int NUM_VOTERS = 5;
    localparam int CHOICE_W   = 3;

    localparam logic [CHOICE_W-1:0] CAND_A  = 3'b001;
    localparam logic [CHOICE_W-1:0] CAND_B  = 3'b010;
    localparam logic [CHOICE_W-1:0] CAND_C  = 3'b100;
    localparam logic [CHOICE_W-1:0] ABSTAIN = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        CLOSED
    } state_t;

    // True only for one of the three legal candidate codes.
    function automatic logic is_candidate(input logic [CHOICE_W-1:0] c);
        return (c == CAND_A) || (c == CAND_B) || (c == CAND_C);
    endfunction

endpackage

// File: rtl/ballot_check.sv
// Combinational ballot validation.
// Ports:
//   voter_id   - slot number presented with the ballot (legal 0..4)
//   choice     - ballot code, must be a single candidate
//   voted_mask - slots that have already voted this session
//   ok         - 1 when the ballot may be stored
module ballot_check
    import vote_pkg::*;
(
    input  logic [2:0]            voter_id,
    input  logic [CHOICE_W-1:0]   choice,
    input  logic [NUM_VOTERS-1:0] voted_mask,
    output logic                  ok
);

    // Widened so ids 5..7 index a defined (zero) bit rather than running
    // off the end of the mask; the range test rejects them anyway.
    logic [7:0] mask_ext;
    logic       in_range;
    logic       dup;

    always_comb begin
        mask_ext = 8'(voted_mask);
        in_range = (voter_id < 3'(NUM_VOTERS));
        dup      = mask_ext[voter_id];
        ok       = in_range && is_candidate(choice) && !dup;
    end

endmodule

// File: rtl/ballot_collector.sv
// Sequential front end for the five-voter majority voter.
// Opens a session on start, accepts one ballot per slot, and closes on
// all-voted, close_req or timeout. Ballots stay frozen with done=1 until the
// next start.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start, close_req    - session open / forced close
//   vote_valid, voter_id, choice - ballot input
//   accept, reject      - one-cycle response pulse per vote_valid cycle
//   ballot1..ballot5    - latched ballots for voter inputs in1..in5
//   voted_mask, vote_count, done - session status
module ballot_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int TMR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  close_req,
    input  logic                  vote_valid,
    input  logic [2:0]            voter_id,
    input  logic [CHOICE_W-1:0]   choice,
    output logic                  accept,
    output logic                  reject,
    output logic [CHOICE_W-1:0]   ballot1,
    output logic [CHOICE_W-1:0]   ballot2,
    output logic [CHOICE_W-1:0]   ballot3,
    output logic [CHOICE_W-1:0]   ballot4,
    output logic [CHOICE_W-1:0]   ballot5,
    output logic [NUM_VOTERS-1:0] voted_mask,
    output logic [2:0]            vote_count,
    output logic                  done
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t                                 state;
    logic [TMR_W-1:0]                       timer;
    logic [NUM_VOTERS-1:0][CHOICE_W-1:0]    ballots;

    logic ok;
    logic take_vote;
    logic last_slot;
    logic timed_out;
    logic close_now;
    logic enter_open;

    ballot_check u_check (
        .voter_id   (voter_id),
        .choice     (choice),
        .voted_mask (voted_mask),
        .ok         (ok)
    );

    always_comb begin
        take_vote  = (state == OPEN) && vote_valid && ok;
        // The ballot being stored this edge may be the fifth one.
        last_slot  = take_vote && (vote_count == 3'(NUM_VOTERS - 1));
        timed_out  = (TIMEOUT != 0) && (timer == TMR_LAST);
        close_now  = (state == OPEN) && (last_slot || close_req || timed_out);
        // start is ignored while a session is open.
        enter_open = start && (state != OPEN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            ballots    <= '0;
            voted_mask <= '0;
            vote_count <= '0;
            done       <= 1'b0;
            accept     <= 1'b0;
            reject     <= 1'b0;
        end else begin
            // Exactly one response pulse per vote_valid cycle.
            accept <= take_vote;
            reject <= vote_valid && !take_vote;

            if (take_vote) begin
                ballots[voter_id]    <= choice;
                voted_mask[voter_id] <= 1'b1;
                vote_count           <= vote_count + 3'd1;
            end

            unique case (state)
                IDLE: begin
                    if (enter_open) state <= OPEN;
                end
                OPEN: begin
                    timer <= timer + 1'b1;
                    if (close_now) begin
                        state <= CLOSED;
                        done  <= 1'b1;
                    end
                end
                CLOSED: begin
                    if (enter_open) begin
                        state <= OPEN;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new session wipes the previous one on the opening edge; no
            // vote can be stored on this edge since the FSM was not OPEN.
            if (enter_open) begin
                timer      <= '0;
                ballots    <= '0;
                voted_mask <= '0;
                vote_count <= '0;
            end
        end
    end

    assign ballot1 = ballots[0];
    assign ballot2 = ballots[1];
    assign ballot3 = ballots[2];
    assign ballot4 = ballots[3];
    assign ballot5 = ballots[4];

endmodule

// File: tb/tb_ballot_collector.sv
module tb_ballot_collector;

    localparam int TMO = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       close_req;
    logic       vote_valid;
    logic [2:0] voter_id;
    logic [2:0] choice;
    logic       accept;
    logic       reject;
    logic [2:0] ballot1, ballot2, ballot3, ballot4, ballot5;
    logic [4:0] voted_mask;
    logic [2:0] vote_count;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model: session open flag, per-slot ballots and flags, and an
    // age counter of OPEN cycles elapsed.
    bit       m_open;
    bit       m_done;
    bit       m_acc;
    bit       m_rej;
    int       m_cnt;
    int       m_age;
    bit [2:0] m_ball [5];
    bit       m_voted[5];

    ballot_collector #(.TIMEOUT(TMO), .TMR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .close_req  (close_req),
        .vote_valid (vote_valid),
        .voter_id   (voter_id),
        .choice     (choice),
        .accept     (accept),
        .reject     (reject),
        .ballot1    (ballot1),
        .ballot2    (ballot2),
        .ballot3    (ballot3),
        .ballot4    (ballot4),
        .ballot5    (ballot5),
        .voted_mask (voted_mask),
        .vote_count (vote_count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_age = 0;
        for (int i = 0; i < 5; i++) begin
            m_ball[i]  = 3'b000;
            m_voted[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [4:0] emask;
        for (int i = 0; i < 5; i++) emask[i] = m_voted[i];
        chk("accept",     8'(accept),     8'(m_acc));
        chk("reject",     8'(reject),     8'(m_rej));
        chk("done",       8'(done),       8'(m_done));
        chk("vote_count", 8'(vote_count), 8'(m_cnt));
        chk("voted_mask", 8'(voted_mask), 8'(emask));
        chk("ballot1",    8'(ballot1),    8'(m_ball[0]));
        chk("ballot2",    8'(ballot2),    8'(m_ball[1]));
        chk("ballot3",    8'(ballot3),    8'(m_ball[2]));
        chk("ballot4",    8'(ballot4),    8'(m_ball[3]));
        chk("ballot5",    8'(ballot5),    8'(m_ball[4]));
    endtask

    // Apply one cycle of inputs, advance the model by the session rules and
    // compare every output just after the edge.
    task automatic step(input logic r, input logic s, input logic c, input logic v,
                        input logic [2:0] id, input logic [2:0] ch);
        int idx;
        rst_n = r; start = s; close_req = c; vote_valid = v; voter_id = id; choice = ch;
        @(posedge clk);
        idx = int'(id);
        if (!r) begin
            m_open = 0; m_done = 0; m_acc = 0; m_rej = 0;
            model_clear();
        end else begin
            m_acc = 0; m_rej = 0;
            if (v) begin
                if (m_open && idx < 5 && $countones(ch) == 1 && !m_voted[idx]) begin
                    m_ball[idx]  = ch;
                    m_voted[idx] = 1'b1;
                    m_cnt++;
                    m_acc = 1;
                end else begin
                    m_rej = 1;
                end
            end
            if (m_open) begin
                m_age++;
                if (m_cnt == 5 || c || m_age == TMO) begin
                    m_open = 0;
                    m_done = 1;
                end
            end else if (s) begin
                m_open = 1;
                m_done = 0;
                model_clear();
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'b000);
    endtask

    initial begin
        logic [2:0] rid, rch;
        rst_n = 1'b0; start = 1'b0; close_req = 1'b0; vote_valid = 1'b0;
        voter_id = 3'd0; choice = 3'b000;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 0, 3'd0, 3'b000);
        step(1'b0, 1'b0, 1'b0, 0, 3'd0, 3'b000);

        // Five consecutive votes fill the session
        step(1'b1, 1'b1, 1'b0, 0, 3'd0, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1, 3'd0, 3'b001);
        step(1'b1, 1'b0, 1'b0, 1, 3'd1, 3'b001);
        step(1'b1, 1'b0, 1'b0, 1, 3'd2, 3'b010);
        step(1'b1, 1'b0, 1'b0, 1, 3'd3, 3'b100);
        step(1'b1, 1'b0, 1'b0, 1, 3'd4, 3'b001);
        chk("t1_done",  8'(done),       8'd1);
        chk("t1_acc",   8'(accept),     8'd1);
        chk("t1_balls", 8'({ballot1, ballot2}), 8'b001_001);
        chk("t1_b345",  8'({ballot3, ballot4}), 8'b010_100);
        chk("t1_b5",    8'(ballot5),    8'b001);
        chk("t1_cnt",   8'(vote_count), 8'd5);
        idle();

        // Duplicate vote rejected
        step(1'b1, 1'b1, 1'b0, 0, 3'd0, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1, 3'd2, 3'b010);
        step(1'b1, 1'b0, 1'b0, 1, 3'd2, 3'b001);
        chk("t2_rej",   8'(reject),     8'd1);
        chk("t2_b3",    8'(ballot3),    8'b010);
        chk("t2_mask",  8'(voted_mask), 8'b00100);

        // Malformed ballots rejected
        step(1'b1, 1'b0, 1'b0, 1, 3'd0, 3'b011);
        step(1'b1, 1'b0, 1'b0, 1, 3'd1, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1, 3'd6, 3'b001);
        chk("t3_rej",   8'(reject),     8'd1);
        chk("t3_mask",  8'(voted_mask), 8'b00100);
        chk("t3_cnt",   8'(vote_count), 8'd1);

        // Vote together with close_req, then reopen
        step(1'b1, 1'b0, 1'b1, 1, 3'd1, 3'b010);
        chk("t5_acc",   8'(accept),     8'd1);
        chk("t5_done",  8'(done),       8'd1);
        chk("t5_b2",    8'(ballot2),    8'b010);
        step(1'b1, 1'b1, 1'b0, 1, 3'd0, 3'b001);
        chk("t5_rej",   8'(reject),     8'd1);
        chk("t5_clear", 8'({done, ballot2, ballot3}), 8'd0);
        chk("t5_cnt",   8'(vote_count), 8'd0);

        // Timeout: session opened on the previous edge, closes 8 OPEN edges later
        step(1'b1, 1'b0, 1'b0, 1, 3'd0, 3'b100);
        for (int i = 0; i < 6; i++) idle();
        chk("t4_open",  8'(done),       8'd0);
        idle();
        chk("t4_done",  8'(done),       8'd1);
        chk("t4_b1",    8'(ballot1),    8'b100);
        chk("t4_rest",  8'({ballot2, ballot3}), 8'd0);
        chk("t4_cnt",   8'(vote_count), 8'd1);

        // Reset mid-session
        step(1'b1, 1'b1, 1'b0, 0, 3'd0, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1, 3'd0, 3'b001);
        step(1'b1, 1'b0, 1'b0, 1, 3'd1, 3'b010);
        step(1'b1, 1'b0, 1'b0, 1, 3'd2, 3'b100);
        step(1'b0, 1'b0, 1'b0, 0, 3'd0, 3'b000);
        chk("t6_mask",  8'(voted_mask), 8'd0);
        chk("t6_b1",    8'(ballot1),    8'd0);
        step(1'b1, 1'b0, 1'b0, 1, 3'd3, 3'b001);
        chk("t6_rej",   8'(reject),     8'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rid = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) rch = 3'(1 << $urandom_range(0, 2));
            else                          rch = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1),
                 rid, rch);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
